// File: rtl/v74x148_irq_encoder.sv
// v74x148_irq_encoder: registered 8-line falling-edge priority encoder with valid/ack handshake,
// overrun tracking and 74x148-style group outputs.
module v74x148_irq_encoder #(
    parameter int NREQ  = 8,
    parameter int AW    = 3,
    parameter int MISSW = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             EI_L,
    input  logic [NREQ-1:0]  I_L,
    input  logic             ACK,
    output logic [AW-1:0]    A,
    output logic             VALID,
    output logic             GS_L,
    output logic             EO_L,
    output logic             OVR,
    output logic [MISSW-1:0] MISS
);
    typedef enum logic {IDLE, PRESENT} state_t;
    state_t state, state_nx;
    logic [NREQ-1:0] iq, pend, fall, clr;
    logic [AW-1:0] top, a_nx;
    logic valid_nx, ovr_ev;
    assign fall   = iq & ~I_L;
    assign clr    = (state == PRESENT && ACK) ? (NREQ'(1) << A) : '0;
    assign ovr_ev = |(fall & pend & ~clr);
    assign GS_L   = ~(~EI_L & |pend);
    assign EO_L   = ~(~EI_L & ~|pend);
    // Ascending scan so the highest set bit is the one left standing.
    always_comb begin
        top = '0;
        for (int i = 0; i < NREQ; i++)
            if (pend[i]) top = AW'(i);
    end
    always_comb begin
        state_nx = state;
        a_nx     = A;
        valid_nx = VALID;
        if (state == IDLE && !EI_L && |pend) begin
            state_nx = PRESENT;
            a_nx     = top;
            valid_nx = 1'b1;
        end else if (state == PRESENT && ACK) begin
            state_nx = IDLE;
            valid_nx = 1'b0;
        end
    end
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
            iq    <= '1;
            pend  <= '0;
            A     <= '0;
            VALID <= 1'b0;
            OVR   <= 1'b0;
            MISS  <= '0;
        end else begin
            state <= state_nx;
            iq    <= I_L;
            pend  <= (pend & ~clr) | fall;
            A     <= a_nx;
            VALID <= valid_nx;
            OVR   <= OVR | ovr_ev;
            MISS  <= (ovr_ev && MISS != '1) ? MISS + 1'b1 : MISS;
        end
    end
endmodule

// File: tb/tb_v74x148_irq_encoder.sv
// tb_v74x148_irq_encoder: directed stimulus with a code scoreboard checked by a presentation monitor.
module tb_v74x148_irq_encoder;
    logic       CLK = 0, RESET = 1, EI_L = 0, ACK = 0;
    logic [7:0] I_L = 8'hFF;
    logic [2:0] A;
    logic       VALID, GS_L, EO_L, OVR;
    logic [3:0] MISS;
    int n_cmp = 0, n_err = 0;
    logic [2:0] exp_q[$];
    logic pv = 0;

    v74x148_irq_encoder dut (
        .CLK(CLK), .RESET(RESET), .EI_L(EI_L), .I_L(I_L), .ACK(ACK),
        .A(A), .VALID(VALID), .GS_L(GS_L), .EO_L(EO_L), .OVR(OVR), .MISS(MISS)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge CLK);
    endtask

    // Every rising VALID is a new presentation and must match the next queued code.
    initial forever begin
        @(negedge CLK);
        if (VALID && !pv) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL present: got A=%0d with nothing expected", A);
            end else begin
                logic [2:0] e;
                e = exp_q.pop_front();
                if (A !== e) begin
                    n_err++;
                    $display("FAIL present: got A=%0d want %0d", A, e);
                end
            end
        end
        pv = VALID;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        tick(2);
        RESET = 0;
        tick();
        chk("rst_a", 8'(A), 0);
        chk("rst_valid", 8'(VALID), 0);
        chk("rst_gs", 8'(GS_L), 1);
        chk("rst_eo", 8'(EO_L), 0);
        chk("rst_ovr", 8'(OVR), 0);
        chk("rst_miss", 8'(MISS), 0);
        EI_L = 1; #1;
        chk("eo_follows_ei", 8'(EO_L), 1);
        EI_L = 0;
        tick();

        // Two simultaneous requests drained with ACK held high.
        I_L = ~8'h44; ACK = 1;
        exp_q.push_back(3'd6); exp_q.push_back(3'd2);
        tick(); chk("dual_wait", 8'(VALID), 0);
        tick(); chk("dual_v1", 8'(VALID), 1);
        tick(); chk("dual_gap", 8'(VALID), 0);
        tick(); chk("dual_v2", 8'(VALID), 1);
        tick(); chk("dual_done", 8'(VALID), 0);
        chk("dual_gs", 8'(GS_L), 1);
        ACK = 0; I_L = 8'hFF;
        tick();

        // Disabled capture, then enable releases the presentation.
        EI_L = 1; I_L = ~8'h20;
        tick(2);
        chk("dis_gs", 8'(GS_L), 1);
        chk("dis_valid", 8'(VALID), 0);
        EI_L = 0; exp_q.push_back(3'd5); #1;
        chk("en_gs", 8'(GS_L), 0);
        tick(); chk("en_valid", 8'(VALID), 1);
        ACK = 1; tick(); ACK = 0; I_L = 8'hFF;
        chk("en_ack", 8'(VALID), 0);
        tick();

        // Re-request on the acknowledge edge: set wins, no overrun.
        I_L = ~8'h10; exp_q.push_back(3'd4);
        tick(2); chk("re_v1", 8'(VALID), 1);
        I_L = 8'hFF; tick();
        I_L = ~8'h10; ACK = 1; exp_q.push_back(3'd4);
        tick(); ACK = 0;
        chk("re_gap", 8'(VALID), 0);
        chk("re_ovr", 8'(OVR), 0);
        chk("re_miss", 8'(MISS), 0);
        chk("re_gs", 8'(GS_L), 0);
        tick(); chk("re_v2", 8'(VALID), 1);
        ACK = 1; I_L = 8'hFF; tick(); ACK = 0;
        tick();

        // Overrun on line 3, then saturate the counter.
        I_L = ~8'h08; exp_q.push_back(3'd3);
        tick(); I_L = 8'hFF;
        tick(); I_L = ~8'h08;
        tick();
        chk("ovr_flag", 8'(OVR), 1);
        chk("ovr_miss1", 8'(MISS), 1);
        for (int i = 0; i < 16; i++) begin
            I_L = 8'hFF; tick();
            I_L = ~8'h08; tick();
        end
        chk("ovr_sat", 8'(MISS), 15);
        chk("ovr_hold_valid", 8'(VALID), 1);
        I_L = 8'hFF; ACK = 1; tick(); ACK = 0;
        chk("ovr_ack", 8'(VALID), 0);
        chk("ovr_gs", 8'(GS_L), 1);
        tick();

        // Reset mid-presentation with several requests pending.
        I_L = ~8'h83; exp_q.push_back(3'd7);
        tick(2); chk("rp_valid", 8'(VALID), 1);
        #2 RESET = 1; I_L = 8'hFF; #1;
        chk("rp_valid0", 8'(VALID), 0);
        chk("rp_a0", 8'(A), 0);
        chk("rp_gs", 8'(GS_L), 1);
        chk("rp_ovr", 8'(OVR), 0);
        chk("rp_miss", 8'(MISS), 0);
        tick(); RESET = 0;
        tick(5);
        chk("rp_quiet", 8'(VALID), 0);
        chk("rp_eo", 8'(EO_L), 0);
        chk("queue_empty", 8'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
